// File: rtl/hwpe_ctrl_arbiter.sv
// Round-robin arbiter sharing one HWPE control port among NumReq requesters.
// One transaction is in flight at a time; a watchdog turns a hung access into an error response.
module hwpe_ctrl_arbiter #(
  parameter int unsigned  NumReq        = 9,
  parameter int unsigned  AddrWidth     = 32,
  parameter int unsigned  DataWidth     = 32,
  parameter int unsigned  TimeoutCycles = 1024,
  localparam int unsigned StrbWidth     = DataWidth / 8,
  localparam int unsigned IdxWidth      = $clog2(NumReq),
  localparam int unsigned CntWidth      = $clog2(TimeoutCycles + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumReq-1:0]                req_valid_i,
  output logic [NumReq-1:0]                req_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0] req_addr_i,
  input  logic [NumReq-1:0]                req_write_i,
  input  logic [NumReq-1:0][DataWidth-1:0] req_wdata_i,
  input  logic [NumReq-1:0][StrbWidth-1:0] req_strb_i,
  output logic [NumReq-1:0]                rsp_valid_o,
  output logic [DataWidth-1:0]             rsp_rdata_o,
  output logic                             rsp_err_o,
  output logic                             mst_valid_o,
  input  logic                             mst_ready_i,
  output logic [AddrWidth-1:0]             mst_addr_o,
  output logic                             mst_write_o,
  output logic [DataWidth-1:0]             mst_wdata_o,
  output logic [StrbWidth-1:0]             mst_strb_o,
  input  logic                             mst_rsp_valid_i,
  input  logic [DataWidth-1:0]             mst_rdata_i,
  input  logic                             mst_err_i,
  output logic                             busy_o,
  output logic                             timeout_o,
  output logic                             stray_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]           state_r;
  logic [IdxWidth-1:0]  ptr_r;
  logic [IdxWidth-1:0]  idx_r;
  logic [CntWidth-1:0]  cnt_r;
  logic [AddrWidth-1:0] addr_r;
  logic                 write_r;
  logic [DataWidth-1:0] wdata_r;
  logic [StrbWidth-1:0] strb_r;
  logic [DataWidth-1:0] rdata_r;
  logic                 err_r;
  logic                 timeout_r;
  logic                 stray_r;

  logic                 found_s;
  logic [IdxWidth-1:0]  winner_s;
  logic [IdxWidth-1:0]  cand_s;
  logic                 grant_s;
  logic                 expire_s;

  // base < NumReq and off <= NumReq, so one conditional subtraction wraps the sum.
  function automatic logic [IdxWidth-1:0] wrap_idx(input logic [IdxWidth-1:0] base,
                                                   input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NumReq) begin
      sum = sum - NumReq;
    end else begin
      sum = sum;
    end
    return sum[IdxWidth-1:0];
  endfunction

  // Round-robin scan starting just after the last winner.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    cand_s   = '0;
    for (int unsigned off = 1; off <= NumReq; off++) begin
      cand_s = wrap_idx(ptr_r, off);
      if (!found_s && req_valid_i[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign grant_s  = (state_r == ST_IDLE) && found_s;
  assign expire_s = ((state_r == ST_REQ) || (state_r == ST_WAIT)) &&
                    (cnt_r == CntWidth'(TimeoutCycles - 1));

  // Requester-side handshake and response decode.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    if (grant_s) begin
      req_ready_o[winner_s] = 1'b1;
    end else begin
      req_ready_o = '0;
    end
    if (state_r == ST_RESP) begin
      rsp_valid_o[idx_r] = 1'b1;
      rsp_rdata_o        = rdata_r;
      rsp_err_o          = err_r;
    end else begin
      rsp_valid_o = '0;
    end
  end

  assign mst_valid_o = (state_r == ST_REQ);
  assign mst_addr_o  = addr_r;
  assign mst_write_o = write_r;
  assign mst_wdata_o = wdata_r;
  assign mst_strb_o  = strb_r;
  assign busy_o      = (state_r != ST_IDLE);
  assign timeout_o   = timeout_r;
  assign stray_o     = stray_r;

  // Transaction FSM, watchdog and captured request/response fields.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      ptr_r     <= IdxWidth'(NumReq - 1);
      idx_r     <= '0;
      cnt_r     <= '0;
      addr_r    <= '0;
      write_r   <= 1'b0;
      wdata_r   <= '0;
      strb_r    <= '0;
      rdata_r   <= '0;
      err_r     <= 1'b0;
      timeout_r <= 1'b0;
      stray_r   <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      stray_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          stray_r <= mst_rsp_valid_i;
          if (grant_s) begin
            ptr_r   <= winner_s;
            idx_r   <= winner_s;
            addr_r  <= req_addr_i[winner_s];
            write_r <= req_write_i[winner_s];
            wdata_r <= req_wdata_i[winner_s];
            strb_r  <= req_strb_i[winner_s];
            cnt_r   <= '0;
            state_r <= ST_REQ;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          // A response before the HWPE has accepted the request cannot be ours.
          stray_r <= mst_rsp_valid_i;
          cnt_r   <= cnt_r + CntWidth'(1);
          if (expire_s) begin
            timeout_r <= 1'b1;
            rdata_r   <= '0;
            err_r     <= 1'b1;
            state_r   <= ST_RESP;
          end else if (mst_ready_i) begin
            state_r <= ST_WAIT;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r + CntWidth'(1);
          if (mst_rsp_valid_i) begin
            rdata_r <= mst_rdata_i;
            err_r   <= mst_err_i;
            state_r <= ST_RESP;
          end else if (expire_s) begin
            timeout_r <= 1'b1;
            rdata_r   <= '0;
            err_r     <= 1'b1;
            state_r   <= ST_RESP;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_RESP: begin
          stray_r <= mst_rsp_valid_i;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_arbiter.sv
// Self-checking bench for hwpe_ctrl_arbiter: directed vector table, corner-case
// sequences, and a randomized run against a transaction-level reference model.
module tb_hwpe_ctrl_arbiter;
  localparam int N  = 9;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [N-1:0]        req_valid, req_ready, req_write, rsp_valid;
  logic [N-1:0][31:0]  req_addr, req_wdata;
  logic [N-1:0][3:0]   req_strb;
  logic [31:0]         rsp_rdata, mst_addr, mst_wdata, mst_rdata;
  logic                rsp_err, mst_valid, mst_ready, mst_write, mst_rsp_valid, mst_err;
  logic [3:0]          mst_strb;
  logic                busy, timeout, stray;

  int total = 0;
  int bad   = 0;

  hwpe_ctrl_arbiter #(.NumReq(N), .AddrWidth(32), .DataWidth(32), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mst_valid_o(mst_valid), .mst_ready_i(mst_ready), .mst_addr_o(mst_addr),
    .mst_write_o(mst_write), .mst_wdata_o(mst_wdata), .mst_strb_o(mst_strb),
    .mst_rsp_valid_i(mst_rsp_valid), .mst_rdata_i(mst_rdata), .mst_err_i(mst_err),
    .busy_o(busy), .timeout_o(timeout), .stray_o(stray)
  );

  typedef struct {
    logic [N-1:0] valid;
    logic [31:0]  addr;
    logic         write;
    logic [31:0]  wdata;
    logic [3:0]   strb;
    logic [31:0]  rdata;
    logic         err;
    int           exp_idx;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Winner gets exactly addr/wdata; every other requester gets a distinct value.
  task automatic set_fields(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                            input logic [3:0] st, input int ref_idx);
    for (int i = 0; i < N; i++) begin
      req_addr[i]  = addr + 32'((i - ref_idx) * 4);
      req_wdata[i] = wd + 32'(i - ref_idx);
      req_write[i] = wr;
      req_strb[i]  = st;
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, " req_ready"}, req_ready, 64'd0);
    chk({nm, " rsp_valid"}, rsp_valid, 64'd0);
    chk({nm, " rsp_rdata"}, rsp_rdata, 64'd0);
    chk({nm, " rsp_err"}, rsp_err, 64'd0);
    chk({nm, " mst_valid"}, mst_valid, 64'd0);
    chk({nm, " mst_addr"}, mst_addr, 64'd0);
    chk({nm, " mst_write"}, mst_write, 64'd0);
    chk({nm, " mst_wdata"}, mst_wdata, 64'd0);
    chk({nm, " mst_strb"}, mst_strb, 64'd0);
    chk({nm, " busy"}, busy, 64'd0);
    chk({nm, " timeout"}, timeout, 64'd0);
    chk({nm, " stray"}, stray, 64'd0);
  endtask

  // Best-case transaction: grant at 0, HWPE ready at 1, response at 2, rsp_valid at 3.
  task automatic best_txn(input string nm, input int idx, input logic [31:0] ea, input logic ew,
                          input logic [31:0] ewd, input logic [3:0] es, input logic [31:0] rd,
                          input logic er, input logic [N-1:0] valid_after,
                          output logic [N-1:0] seen);
    @(negedge clk);
    seen = req_ready;
    chk({nm, " ready"}, req_ready, 64'(1) << idx);
    step();
    req_valid = valid_after;
    mst_ready = 1'b1;
    @(negedge clk);
    chk({nm, " mst_valid"}, mst_valid, 64'd1);
    chk({nm, " busy"}, busy, 64'd1);
    chk({nm, " mst_addr"}, mst_addr, ea);
    chk({nm, " mst_write"}, mst_write, ew);
    chk({nm, " mst_wdata"}, mst_wdata, ewd);
    chk({nm, " mst_strb"}, mst_strb, es);
    chk({nm, " ready in REQ"}, req_ready, 64'd0);
    step();
    mst_ready     = 1'b0;
    mst_rsp_valid = 1'b1;
    mst_rdata     = rd;
    mst_err       = er;
    @(negedge clk);
    chk({nm, " mst_valid drop"}, mst_valid, 64'd0);
    chk({nm, " rsp early"}, rsp_valid, 64'd0);
    step();
    mst_rsp_valid = 1'b0;
    mst_rdata     = '0;
    mst_err       = 1'b0;
    @(negedge clk);
    chk({nm, " rsp_valid"}, rsp_valid, 64'(1) << idx);
    chk({nm, " rsp_rdata"}, rsp_rdata, rd);
    chk({nm, " rsp_err"}, rsp_err, er);
    chk({nm, " ready in RESP"}, req_ready, 64'd0);
    chk({nm, " stray"}, stray, 64'd0);
    step();
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  logic [N-1:0] seen, pend;
  int           grants [N];
  int           hs, g, rc, sc, free_at, stray_at, last, owner, w;
  logic [31:0]  ea, ewd, exp_rd;
  logic         ew, exp_er;
  logic [3:0]   es;

  initial begin
    tbl[0] = '{9'h008, 32'h0000_0100, 1'b0, 32'h0000_0000, 4'hF, 32'hCAFE_0001, 1'b0, 3};
    tbl[1] = '{9'h1FF, 32'h0000_0200, 1'b1, 32'h1111_2222, 4'h3, 32'h0000_0000, 1'b0, 4};
    tbl[2] = '{9'h001, 32'h0000_0204, 1'b1, 32'hDEAD_BEEF, 4'hC, 32'h0000_0000, 1'b1, 0};
    tbl[3] = '{9'h101, 32'h0000_0300, 1'b0, 32'h0000_0000, 4'hF, 32'h1234_5678, 1'b0, 8};
    tbl[4] = '{9'h101, 32'h0000_0304, 1'b0, 32'h0000_0000, 4'hF, 32'hA5A5_A5A5, 1'b1, 0};
    tbl[5] = '{9'h006, 32'h0000_0400, 1'b1, 32'h0BAD_F00D, 4'h1, 32'h0000_0000, 1'b0, 1};
    tbl[6] = '{9'h081, 32'h0000_0500, 1'b0, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF, 1'b0, 7};
    tbl[7] = '{9'h100, 32'h0000_0600, 1'b1, 32'h0000_0001, 4'hF, 32'h0000_0000, 1'b0, 8};

    rst = 1'b1;
    req_valid = '0; mst_ready = 1'b0; mst_rsp_valid = 1'b0; mst_rdata = '0; mst_err = 1'b0;
    set_fields(32'h0, 1'b0, 32'h0, 4'h0, 0);
    step();
    step();
    @(negedge clk);
    check_zero("reset");
    step();
    rst = 1'b0;

    // Directed vector table, pointer history carried from row to row.
    for (int r = 0; r < 8; r++) begin
      req_valid = tbl[r].valid;
      set_fields(tbl[r].addr, tbl[r].write, tbl[r].wdata, tbl[r].strb, tbl[r].exp_idx);
      best_txn($sformatf("vec%0d", r), tbl[r].exp_idx, tbl[r].addr, tbl[r].write, tbl[r].wdata,
               tbl[r].strb, tbl[r].rdata, tbl[r].err, '0, seen);
    end

    // Fairness: everyone requests continuously, last winner was 8.
    for (int i = 0; i < N; i++) grants[i] = 0;
    req_valid = '1;
    set_fields(32'h1000, 1'b1, 32'h5000, 4'hF, 0);
    for (int k = 0; k <= N; k++) begin
      best_txn($sformatf("fair%0d", k), k % N, 32'h1000 + 32'((k % N) * 4), 1'b1,
               32'h5000 + 32'(k % N), 4'hF, 32'h7700 + 32'(k), 1'b0, '1, seen);
      if (k < N) begin
        for (int i = 0; i < N; i++) grants[i] += int'(seen[i]);
      end
    end
    for (int i = 0; i < N; i++) chk($sformatf("fair count%0d", i), grants[i], 64'd1);
    req_valid = '0;

    // Backpressure: HWPE holds ready low for 5 cycles.
    req_valid = 9'h004;
    set_fields(32'h700, 1'b1, 32'h7777_8888, 4'hA, 2);
    @(negedge clk);
    chk("bp ready", req_ready, 64'h004);
    step();
    req_valid = '0;
    hs = 0;
    for (int c = 1; c <= 8; c++) begin
      mst_ready     = (c == 6);
      mst_rsp_valid = (c == 7);
      mst_rdata     = (c == 7) ? 32'h0000_BEEF : 32'h0;
      @(negedge clk);
      if (mst_valid && mst_ready) hs++;
      chk("bp mst_valid", mst_valid, c <= 6);
      chk("bp busy", busy, 64'd1);
      chk("bp rsp_valid", rsp_valid, (c == 8) ? 64'h004 : 64'h0);
      if (c <= 6) begin
        chk("bp mst_addr", mst_addr, 64'h700);
        chk("bp mst_wdata", mst_wdata, 64'h7777_8888);
      end
      if (c == 8) chk("bp rsp_rdata", rsp_rdata, 64'h0000_BEEF);
      step();
    end
    mst_ready = 1'b0; mst_rsp_valid = 1'b0; mst_rdata = '0;
    chk("bp handshakes", hs, 64'd1);

    // Watchdog expiry, then a late response that must be dropped.
    req_valid = 9'h020;
    set_fields(32'h800, 1'b0, 32'h0, 4'hF, 5);
    @(negedge clk);
    chk("to ready", req_ready, 64'h020);
    step();
    req_valid = '0;
    for (int c = 1; c <= 21; c++) begin
      mst_ready     = (c == 1);
      mst_rsp_valid = (c == 19);
      mst_rdata     = (c == 19) ? 32'hBAD0_BAD0 : 32'h0;
      @(negedge clk);
      chk("to timeout", timeout, c == 17);
      chk("to rsp_valid", rsp_valid, (c == 17) ? 64'h020 : 64'h0);
      chk("to stray", stray, c == 20);
      chk("to mst_valid", mst_valid, c == 1);
      chk("to busy", busy, c <= 17);
      if (c == 17) begin
        chk("to rsp_err", rsp_err, 64'd1);
        chk("to rsp_rdata", rsp_rdata, 64'd0);
      end
      step();
    end
    mst_ready = 1'b0; mst_rsp_valid = 1'b0; mst_rdata = '0;

    // Response on the expiry cycle wins over the watchdog.
    req_valid = 9'h040;
    set_fields(32'h880, 1'b0, 32'h0, 4'hF, 6);
    @(negedge clk);
    chk("sim ready", req_ready, 64'h040);
    step();
    req_valid = '0;
    for (int c = 1; c <= 19; c++) begin
      mst_ready     = (c == 1);
      mst_rsp_valid = (c == 16);
      mst_rdata     = (c == 16) ? 32'h5151_AAAA : 32'h0;
      @(negedge clk);
      chk("sim timeout", timeout, 64'd0);
      chk("sim stray", stray, 64'd0);
      chk("sim rsp_valid", rsp_valid, (c == 17) ? 64'h040 : 64'h0);
      if (c == 17) begin
        chk("sim rsp_rdata", rsp_rdata, 64'h5151_AAAA);
        chk("sim rsp_err", rsp_err, 64'd0);
      end
      step();
    end
    mst_ready = 1'b0; mst_rsp_valid = 1'b0; mst_rdata = '0;

    // Reset while waiting for the HWPE response.
    req_valid = 9'h100;
    set_fields(32'h900, 1'b1, 32'h9999_0000, 4'hF, 8);
    @(negedge clk);
    chk("rstmid ready", req_ready, 64'h100);
    step();
    req_valid = '0;
    mst_ready = 1'b1;
    step();
    mst_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid busy before", busy, 64'd1);
    step();
    rst = 1'b0;
    @(negedge clk);
    check_zero("rstmid");
    step();
    req_valid = 9'h101;
    set_fields(32'hA00, 1'b0, 32'h0, 4'hF, 0);
    best_txn("rstmid next", 0, 32'hA00, 1'b0, 32'h0, 4'hF, 32'h0000_00A0, 1'b0, '0, seen);

    // Randomized run against a transaction-level timeline model.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    pend = '0; g = -100; rc = -100; sc = -100; free_at = 0; stray_at = -100;
    last = N - 1; owner = 0; exp_rd = '0; exp_er = 1'b0;
    ea = '0; ewd = '0; ew = 1'b0; es = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i] && $urandom_range(31, 0) == 0) begin
          pend[i] = 1'b0;
        end else if (!pend[i] && $urandom_range(3, 0) == 0) begin
          pend[i]      = 1'b1;
          req_addr[i]  = $urandom;
          req_wdata[i] = $urandom;
          req_write[i] = 1'($urandom_range(1, 0));
          req_strb[i]  = 4'($urandom_range(15, 0));
        end
      end
      req_valid     = pend;
      mst_ready     = (cyc == rc);
      mst_rsp_valid = 1'b0;
      mst_rdata     = '0;
      mst_err       = 1'b0;
      if (cyc == sc) begin
        mst_rsp_valid = 1'b1;
        mst_rdata     = exp_rd;
        mst_err       = exp_er;
      end else if (cyc == sc + 1 && $urandom_range(2, 0) == 0) begin
        mst_rsp_valid = 1'b1;
        mst_rdata     = $urandom;
        mst_err       = 1'b1;
        stray_at      = cyc + 1;
      end
      @(negedge clk);
      w = (cyc >= free_at) ? rr_pick(pend, last) : -1;
      chk("rnd ready", req_ready, (w >= 0) ? (64'(1) << w) : 64'd0);
      chk("rnd mst_valid", mst_valid, cyc >= g + 1 && cyc <= rc);
      chk("rnd busy", busy, cyc >= g + 1 && cyc <= sc + 1);
      if (cyc >= g + 1 && cyc <= rc) begin
        chk("rnd mst_addr", mst_addr, ea);
        chk("rnd mst_write", mst_write, ew);
        chk("rnd mst_wdata", mst_wdata, ewd);
        chk("rnd mst_strb", mst_strb, es);
      end
      chk("rnd rsp_valid", rsp_valid, (cyc == sc + 1) ? (64'(1) << owner) : 64'd0);
      if (cyc == sc + 1) begin
        chk("rnd rsp_rdata", rsp_rdata, exp_rd);
        chk("rnd rsp_err", rsp_err, exp_er);
      end
      chk("rnd stray", stray, cyc == stray_at);
      chk("rnd timeout", timeout, 64'd0);
      if (w >= 0) begin
        owner   = w;
        last    = w;
        ea      = req_addr[w];
        ewd     = req_wdata[w];
        ew      = req_write[w];
        es      = req_strb[w];
        pend[w] = 1'b0;
        g       = cyc;
        rc      = g + 1 + int'($urandom_range(3, 0));
        sc      = rc + 1 + int'($urandom_range(3, 0));
        free_at = sc + 2;
        exp_rd  = $urandom;
        exp_er  = ($urandom_range(3, 0) == 0);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hwpe_ctrl_arbiter.md
# hwpe_ctrl_arbiter

Shares the single 32-bit HWPE peripheral control port between several requesters (the Snitch cores' narrow AXI→TCDM control path plus optional debug/DMA agents) inside the cluster tile. Grants one request at a time with round-robin fairness and keeps exactly one transaction outstanding. Routes the response back to the originating requester. A watchdog converts a hung HWPE transaction into an error response so that no core stalls forever.

## Interface
Parameters:
- NumReq, default 9: number of requesters (≥2).
- AddrWidth, default 32: control address width.
- DataWidth, default 32: control data width; StrbWidth = DataWidth/8.
- TimeoutCycles, default 1024: cycles allowed in REQ+WAIT before forced error; counter width is clog2(TimeoutCycles+1).

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  NumReq  per-requester request valid.
- req_ready_o  out  NumReq  per-requester accept (one-hot, at most one bit).
- req_addr_i  in  NumReq×AddrWidth  request address.
- req_write_i  in  NumReq  1 = write.
- req_wdata_i  in  NumReq×DataWidth  write data.
- req_strb_i  in  NumReq×StrbWidth  byte strobes.
- rsp_valid_o  out  NumReq  one-hot response pulse to the owner.
- rsp_rdata_o  out  DataWidth  response data, shared across requesters.
- rsp_err_o  out  1  response error, valid with rsp_valid_o.
- mst_valid_o  out  1  request to the HWPE control port.
- mst_ready_i  in  1  HWPE grant.
- mst_addr_o / mst_write_o / mst_wdata_o / mst_strb_o  out  AddrWidth/1/DataWidth/StrbWidth  registered request fields.
- mst_rsp_valid_i  in  1  HWPE response valid.
- mst_rdata_i  in  DataWidth  HWPE read data.
- mst_err_i  in  1  HWPE error.
- busy_o  out  1  high in any state other than IDLE.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.
- stray_o  out  1  one-cycle pulse when a response is dropped.

## Operation
- FSM states: IDLE → REQ → WAIT → RESP → IDLE.
- **IDLE:**
  - If any req_valid_i is set, select winner = first set bit scanning from (ptr+1) mod NumReq upward with wrap.
  - Assert req_ready_o[winner] combinationally in the same cycle; this completes the requester handshake.
  - Capture addr/write/wdata/strb and the index into registers; ptr ← winner; go to REQ.
- **REQ:**
  - mst_valid_o = 1; mst_* fields held stable from the registers.
  - On mst_ready_i, go to WAIT.
- **WAIT:** on mst_rsp_valid_i, register mst_rdata_i and mst_err_i, then go to RESP.
- **RESP:**
  - rsp_valid_o[idx] = 1 for exactly one cycle, with rsp_rdata_o/rsp_err_o driven from the registers; go to IDLE.
  - No new grant is made in RESP.
- **Watchdog:**
  - The counter clears on entry to REQ and increments every cycle in REQ and WAIT.
  - When the count equals TimeoutCycles−1 and no mst_rsp_valid_i arrives in that cycle:
    - pulse timeout_o and go to RESP with rsp_err_o = 1 and rsp_rdata_o = 0;
    - mst_valid_o drops in the next cycle, abandoning the transaction.
- **Stray responses:** mst_rsp_valid_i in IDLE, REQ or RESP is ignored and pulses stray_o. This covers late responses after a timeout and responses arriving in the grant cycle.
- **Simultaneous events:** in the cycle where the watchdog expires, mst_rsp_valid_i takes priority; the normal response wins and no timeout is raised.
- **Round-robin pointer:** reset value NumReq−1, so requester 0 has first priority after reset. The pointer updates only on grant.
- **Request-field stability:** a requester must hold its request fields while req_valid_i is high and req_ready_o is low. Dropping req_valid_i before the grant is legal.

## Timing
- Reset values (rst_i high at a clock edge): state = IDLE, ptr = NumReq−1, counter = 0. All outputs are 0: req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, mst_*, busy_o, timeout_o, stray_o.
- Reset mid-transaction abandons the in-flight request without issuing a response. Master-side cleanup is the HWPE reset's responsibility.
- Best-case latency:
  - grant at cycle 0 (IDLE);
  - mst_valid_o at cycle 1 with mst_ready_i in cycle 1;
  - mst_rsp_valid_i at cycle 2;
  - rsp_valid_o at cycle 3.
- Throughput: one transaction per 4 cycles.
- req_ready_o is the only combinational output (it depends on req_valid_i and ptr). All other outputs are registered or decoded from the state.
- mst_valid_o, once asserted, stays high until mst_ready_i or the watchdog fires; it never glitches.

## Test plan
- **Single read:** req 3 reads 0x100; HWPE grants in 1 cycle and returns 0xCAFE0001 one cycle later → req_ready_o = 0x008 at cycle 0; rsp_valid_o = 0x008 at cycle 3 with rdata 0xCAFE0001, err 0.
- **Fairness:** all 9 requesters hold valid continuously → grant order 0,1,…,8,0; each requester gets exactly one grant per 9 transactions.
- **Backpressure:** mst_ready_i held low 5 cycles → mst_addr_o/mst_wdata_o are stable all 6 cycles; exactly one mst handshake; busy_o stays 1.
- **Timeout:** TimeoutCycles = 16, no response → timeout_o pulses once, owner gets rsp_err_o = 1 with rdata 0. A late mst_rsp_valid_i afterwards → stray_o = 1, no rsp_valid_o.
- **Simultaneous events:** response arrives on the expiry cycle → normal response with HWPE data, no timeout_o.
- **Reset mid-operation:** rst_i asserted in WAIT → next cycle all outputs 0 and state IDLE; next grant goes to requester 0 if it is valid.
